// File: rtl/rr_grant_sequencer_pkg.sv
// rr_grant_sequencer_pkg: shared types for the round-robin grant sequencer
package rr_grant_sequencer_pkg;
  typedef enum logic {GS_IDLE, GS_GRANTED} grant_state_t;
endpackage

// File: rtl/idx_to_oh.sv
// idx_to_oh: binary index to one-hot encoder, DIRECTION "LSB0" or "MSB0"
module idx_to_oh #(
  parameter int    N         = 4,
  parameter int    W         = $clog2(N),
  parameter string DIRECTION = "LSB0"
) (
  input  logic [W-1:0] idx,
  output logic [N-1:0] oh
);
  logic [N-1:0] lsb;
  assign lsb = N'(1) << idx;
  for (genvar i = 0; i < N; i++) begin : g_bit
    assign oh[i] = DIRECTION == "MSB0" ? lsb[N-1-i] : lsb[i];
  end
endmodule

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating-priority pick, first set bit of mask from start wrapping at N
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] mask,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);
  localparam logic [W:0] NW = (W+1)'(N);
  logic [N-1:0] rot;
  logic [W:0] s;
  // descending scan so the lowest rotated offset wins
  always_comb begin
    rot = N'({mask, mask} >> start);
    found = 1'b0;
    idx = '0;
    s = '0;
    for (int i = N-1; i >= 0; i--)
      if (rot[i]) begin
        found = 1'b1;
        s = {1'b0, start} + (W+1)'(i);
        idx = W'(s >= NW ? s - NW : s);
      end
  end
endmodule

// File: rtl/rr_grant_sequencer.sv
// rr_grant_sequencer: round-robin arbiter holding one grant until accepted, then rotating priority.
// Define RR_GRANT_LOCK_EN to add grant_lock, which re-grants the same requester for bursts.
module rr_grant_sequencer
  import rr_grant_sequencer_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4,
  parameter int INDEX_WIDTH    = $clog2(NUM_REQUESTERS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQUESTERS-1:0] request,
  input  logic                      grant_accept,
`ifdef RR_GRANT_LOCK_EN
  input  logic                      grant_lock,
`endif
  output logic                      grant_valid,
  output logic [INDEX_WIDTH-1:0]    grant_idx,
  output logic [NUM_REQUESTERS-1:0] grant_oh
);
  localparam logic [INDEX_WIDTH-1:0] LAST = INDEX_WIDTH'(NUM_REQUESTERS-1);
  grant_state_t state;
  logic [INDEX_WIDTH-1:0] ptr, ptr_nxt, start, pick_idx;
  logic [NUM_REQUESTERS-1:0] mask, oh;
  logic lock, accept, found;
`ifdef RR_GRANT_LOCK_EN
  assign lock = grant_lock;
`else
  assign lock = 1'b0;
`endif
  assign accept = state == GS_GRANTED && grant_accept;
  assign ptr_nxt = lock ? ptr : grant_idx == LAST ? '0 : grant_idx + INDEX_WIDTH'(1);
  // a locked accept restarts the scan at the holder so it keeps the grant while requesting
  assign start = state == GS_IDLE ? ptr : lock ? grant_idx : ptr_nxt;
  assign mask = (state == GS_IDLE || lock) ? request : request & ~grant_oh;
  rr_pick #(.N(NUM_REQUESTERS), .W(INDEX_WIDTH)) u_pick (
    .mask  (mask),
    .start (start),
    .found (found),
    .idx   (pick_idx)
  );
  idx_to_oh #(.N(NUM_REQUESTERS), .W(INDEX_WIDTH), .DIRECTION("LSB0")) u_oh (
    .idx (grant_idx),
    .oh  (oh)
  );
  assign grant_valid = state == GS_GRANTED;
  assign grant_oh = grant_valid ? oh : '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= GS_IDLE;
      grant_idx <= '0;
      ptr <= '0;
    end else if (state == GS_IDLE || accept) begin
      state <= found ? GS_GRANTED : GS_IDLE;
      grant_idx <= found ? pick_idx : '0;
      if (accept) ptr <= ptr_nxt;
    end
  a_oh_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(grant_oh));
  a_valid_oh: assert property (@(posedge clk) disable iff (reset) grant_valid |-> grant_oh != '0);
endmodule

// File: tb/tb_rr_grant_sequencer.sv
// tb_rr_grant_sequencer: directed scoreboard bench for rr_grant_sequencer (N=4 and N=3 instances)
module tb_rr_grant_sequencer;
  logic clk = 1'b0, reset = 1'b1;
  logic [3:0] request = '0, grant_oh;
  logic grant_accept = 1'b0, grant_valid;
  logic [1:0] grant_idx;
  logic [2:0] req3 = '0, oh3;
  logic acc3 = 1'b0, v3;
  logic [1:0] idx3;
`ifdef RR_GRANT_LOCK_EN
  logic grant_lock = 1'b0;
`endif
  int checks = 0, failures = 0;
  typedef struct {string tag; logic v; int idx;} exp_t;
  exp_t q[$], q3[$];
  always #5 clk = ~clk;
  rr_grant_sequencer #(.NUM_REQUESTERS(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .request      (request),
    .grant_accept (grant_accept),
`ifdef RR_GRANT_LOCK_EN
    .grant_lock   (grant_lock),
`endif
    .grant_valid  (grant_valid),
    .grant_idx    (grant_idx),
    .grant_oh     (grant_oh)
  );
  rr_grant_sequencer #(.NUM_REQUESTERS(3)) dut3 (
    .clk          (clk),
    .reset        (reset),
    .request      (req3),
    .grant_accept (acc3),
`ifdef RR_GRANT_LOCK_EN
    .grant_lock   (1'b0),
`endif
    .grant_valid  (v3),
    .grant_idx    (idx3),
    .grant_oh     (oh3)
  );
  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask
  task automatic step(input string tag, input logic [3:0] r, input logic a, input logic l, input logic ev, input int ei);
    exp_t e;
    @(negedge clk);
    request = r;
    grant_accept = a;
`ifdef RR_GRANT_LOCK_EN
    grant_lock = l;
`else
    if (l) $display("note: lock requested without RR_GRANT_LOCK_EN");
`endif
    q.push_back('{tag, ev, ei});
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk({e.tag, ".valid"}, {3'b0, grant_valid}, {3'b0, e.v});
    chk({e.tag, ".idx"}, {2'b0, grant_idx}, e.v ? 4'(e.idx) : 4'd0);
    chk({e.tag, ".oh"}, grant_oh, e.v ? 4'b0001 << e.idx : 4'b0000);
  endtask
  task automatic step3(input string tag, input logic [2:0] r, input logic a, input logic ev, input int ei);
    exp_t e;
    @(negedge clk);
    req3 = r;
    acc3 = a;
    q3.push_back('{tag, ev, ei});
    @(posedge clk);
    #1;
    e = q3.pop_front();
    chk({e.tag, ".valid"}, {3'b0, v3}, {3'b0, e.v});
    chk({e.tag, ".idx"}, {2'b0, idx3}, e.v ? 4'(e.idx) : 4'd0);
    chk({e.tag, ".oh"}, {1'b0, oh3}, e.v ? 4'b0001 << e.idx : 4'b0000);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", {3'b0, grant_valid}, 4'd0);
    chk("rst.idx", {2'b0, grant_idx}, 4'd0);
    chk("rst.oh", grant_oh, 4'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step("idle", 4'b0000, 1'b0, 1'b0, 1'b0, 0);
    step("t2.g1", 4'b1010, 1'b1, 1'b0, 1'b1, 1);
    step("t2.g3", 4'b1000, 1'b1, 1'b0, 1'b1, 3);
    step("t2.idle", 4'b0000, 1'b1, 1'b0, 1'b0, 0);
    step("t2.idle2", 4'b0000, 1'b0, 1'b0, 1'b0, 0);
    step("t3.g0", 4'b1111, 1'b1, 1'b0, 1'b1, 0);
    step("t3.g1", 4'b1111, 1'b1, 1'b0, 1'b1, 1);
    step("t3.g2", 4'b1111, 1'b1, 1'b0, 1'b1, 2);
    step("t3.g3", 4'b1111, 1'b1, 1'b0, 1'b1, 3);
    step("t3.g0b", 4'b1111, 1'b1, 1'b0, 1'b1, 0);
    step("t3.g1b", 4'b1111, 1'b1, 1'b0, 1'b1, 1);
    step("t3.idle", 4'b0000, 1'b1, 1'b0, 1'b0, 0);
    step("t4.g2", 4'b0100, 1'b0, 1'b0, 1'b1, 2);
    step("t4.hold1", 4'b1011, 1'b0, 1'b0, 1'b1, 2);
    step("t4.hold2", 4'b0001, 1'b0, 1'b0, 1'b1, 2);
    step("t4.hold3", 4'b1111, 1'b0, 1'b0, 1'b1, 2);
    step("t4.hold4", 4'b1101, 1'b0, 1'b0, 1'b1, 2);
    step("t4.g3", 4'b1111, 1'b1, 1'b0, 1'b1, 3);
    #2 reset = 1'b1;
    #1;
    chk("t5.async.valid", {3'b0, grant_valid}, 4'd0);
    chk("t5.async.idx", {2'b0, grant_idx}, 4'd0);
    chk("t5.async.oh", grant_oh, 4'd0);
    @(negedge clk);
    request = 4'b0000;
    grant_accept = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    step("t5.g3", 4'b1000, 1'b0, 1'b0, 1'b1, 3);
    step("t5.g0", 4'b1001, 1'b1, 1'b0, 1'b1, 0);
    step("t5.idle", 4'b0000, 1'b1, 1'b0, 1'b0, 0);
    step("lone.g1", 4'b0010, 1'b1, 1'b0, 1'b1, 1);
    step("lone.gap", 4'b0010, 1'b1, 1'b0, 1'b0, 0);
    step("lone.g1b", 4'b0010, 1'b1, 1'b0, 1'b1, 1);
    step("lone.gap2", 4'b0000, 1'b1, 1'b0, 1'b0, 0);
`ifdef RR_GRANT_LOCK_EN
    step("lock.g0", 4'b0011, 1'b0, 1'b0, 1'b1, 0);
    step("lock.b1", 4'b0011, 1'b1, 1'b1, 1'b1, 0);
    step("lock.b2", 4'b0011, 1'b1, 1'b1, 1'b1, 0);
    step("lock.b3", 4'b0011, 1'b1, 1'b1, 1'b1, 0);
    step("lock.rel", 4'b0011, 1'b1, 1'b0, 1'b1, 1);
`endif
    step3("n3.g2", 3'b100, 1'b1, 1'b1, 2);
    step3("n3.wrap", 3'b101, 1'b1, 1'b1, 0);
    step3("n3.idle", 3'b001, 1'b1, 1'b0, 0);
    step3("n3.g1", 3'b011, 1'b1, 1'b1, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
